// File: rtl/seq_checker.sv
// Receive-side checker for the 4-bit Johnson sequence: samples SIN on a divided tick,
// rebuilds the state window, locks to the sequence phase and counts bit errors.
module seq_checker #(
    parameter int unsigned DIV    = 27000000,
    parameter int unsigned LOCK_N = 8,
    parameter int unsigned MISS_N = 3
) (
    input  logic       exCLK,
    input  logic       R1,
    input  logic       CLKen,
    input  logic       SIN,
    output logic [3:0] QW,
    output logic       LOCK,
    output logic       ERR,
    output logic [7:0] ERRCNT,
    output logic       SMPL
);

    localparam int unsigned CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned GW        = $clog2(LOCK_N + 1);
    localparam int unsigned MW        = $clog2(MISS_N + 1);
    localparam int unsigned FILL_FULL = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [2:0]      fill;
    logic [GW-1:0]   good;
    logic [MW-1:0]   miss;

    logic            tick_c;
    logic            pred_c;
    logic            match_c;
    logic [3:0]      win_in_c;
    logic            win_ok_c;
    logic [2:0]      fill_inc_c;
    logic [GW-1:0]   good_inc_c;
    logic [MW-1:0]   miss_inc_c;

    logic            shift_bit_c;
    logic            err_c;
    logic [2:0]      fill_nx_c;
    logic [GW-1:0]   good_nx_c;
    logic [MW-1:0]   miss_nx_c;

    // Sample-tick divider; frozen while CLKen is low
    always_ff @(posedge exCLK or negedge R1) begin
        if (!R1) begin
            cnt <= '0;
        end else if (CLKen) begin
            cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
        end
    end

    assign tick_c     = CLKen & (cnt == CW'(DIV - 1));
    assign pred_c     = ~QW[3] | (~QW[2] & QW[1]);
    assign match_c    = (SIN == pred_c);
    assign win_in_c   = {QW[2:0], SIN};
    assign fill_inc_c = (fill == 3'(FILL_FULL)) ? fill : fill + 3'd1;
    assign good_inc_c = good + GW'(1);
    assign miss_inc_c = miss + MW'(1);

    // The eight legal Johnson states, as seen through the window
    always_comb begin
        win_ok_c = 1'b0;
        case (win_in_c)
            4'b0000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000: win_ok_c = 1'b1;
            default:                            win_ok_c = 1'b0;
        endcase
    end

    always_ff @(posedge exCLK or negedge R1) begin
        if (!R1) begin
            state <= HUNT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (tick_c) begin
            case (state)
                HUNT: begin
                    if ((fill_inc_c == 3'(FILL_FULL)) && win_ok_c) state_nx = VERIFY;
                end
                VERIFY: begin
                    if (!match_c)                          state_nx = HUNT;
                    else if (good_inc_c == GW'(LOCK_N))    state_nx = LOCKED;
                end
                LOCKED: begin
                    if (!match_c && (miss_inc_c == MW'(MISS_N))) state_nx = HUNT;
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    // Per-state window source and counter updates; applied only on a sample edge
    always_comb begin
        shift_bit_c = SIN;
        err_c       = 1'b0;
        fill_nx_c   = fill;
        good_nx_c   = good;
        miss_nx_c   = miss;
        case (state)
            HUNT: begin
                fill_nx_c = fill_inc_c;
                good_nx_c = '0;
            end
            VERIFY: begin
                if (match_c) begin
                    good_nx_c = good_inc_c;
                    miss_nx_c = '0;
                end else begin
                    fill_nx_c = '0;
                    good_nx_c = '0;
                end
            end
            LOCKED: begin
                shift_bit_c = pred_c;
                if (match_c) begin
                    miss_nx_c = '0;
                end else begin
                    err_c     = 1'b1;
                    miss_nx_c = miss_inc_c;
                    if (miss_inc_c == MW'(MISS_N)) begin
                        fill_nx_c = '0;
                        miss_nx_c = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge exCLK or negedge R1) begin
        if (!R1) begin
            QW     <= '0;
            fill   <= '0;
            good   <= '0;
            miss   <= '0;
            LOCK   <= 1'b0;
            ERR    <= 1'b0;
            ERRCNT <= '0;
            SMPL   <= 1'b0;
        end else begin
            SMPL <= tick_c;
            ERR  <= tick_c & err_c;
            LOCK <= (state_nx == LOCKED);
            if (tick_c) begin
                QW   <= {QW[2:0], shift_bit_c};
                fill <= fill_nx_c;
                good <= good_nx_c;
                miss <= miss_nx_c;
                if (err_c && (ERRCNT != 8'hFF)) ERRCNT <= ERRCNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench for seq_checker: a table-driven reference model predicts
// QW/LOCK/ERR/ERRCNT for every sample and the monitor compares on each SMPL pulse.
module tb_seq_checker;

    localparam int unsigned DIV    = 4;
    localparam int unsigned LOCK_N = 8;
    localparam int unsigned MISS_N = 3;

    typedef struct packed {
        logic [3:0] qw;
        logic       lock;
        logic       err;
        logic [7:0] errcnt;
    } exp_t;

    logic       exCLK = 1'b0;
    logic       R1    = 1'b0;
    logic       CLKen = 1'b0;
    logic       SIN   = 1'b0;
    logic [3:0] QW;
    logic       LOCK;
    logic       ERR;
    logic [7:0] ERRCNT;
    logic       SMPL;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [3:0] seq_tbl [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [7:0] pat = 8'b0001_1110;
    int         gph = 0;

    int         m_st, m_fill, m_good, m_miss, m_errcnt;
    logic [3:0] m_qw;

    seq_checker #(.DIV(DIV), .LOCK_N(LOCK_N), .MISS_N(MISS_N)) dut (
        .exCLK (exCLK),
        .R1    (R1),
        .CLKen (CLKen),
        .SIN   (SIN),
        .QW    (QW),
        .LOCK  (LOCK),
        .ERR   (ERR),
        .ERRCNT(ERRCNT),
        .SMPL  (SMPL)
    );

    always #5 exCLK = ~exCLK;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int seq_idx(input logic [3:0] w);
        for (int i = 0; i < 8; i++) if (seq_tbl[i] == w) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_fill = 0; m_good = 0; m_miss = 0; m_errcnt = 0; m_qw = 4'b0000;
    endtask

    // Reference: expected next bit is the low bit of the following table entry
    task automatic model_step(input logic b, output exp_t e);
        int   i;
        logic p;
        logic mis;
        mis = 1'b0;
        i   = seq_idx(m_qw);
        p   = (i < 0) ? 1'b0 : seq_tbl[(i + 1) % 8][0];
        case (m_st)
            0: begin
                m_qw = {m_qw[2:0], b};
                if (m_fill < 4) m_fill++;
                if (m_fill == 4 && seq_idx(m_qw) >= 0) begin m_st = 1; m_good = 0; end
            end
            1: begin
                m_qw = {m_qw[2:0], b};
                if (b == p) begin
                    m_good++;
                    if (m_good == int'(LOCK_N)) begin m_st = 2; m_miss = 0; end
                end else begin
                    m_st = 0; m_fill = 0; m_good = 0;
                end
            end
            default: begin
                m_qw = {m_qw[2:0], p};
                if (b != p) begin
                    mis = 1'b1;
                    if (m_errcnt < 255) m_errcnt++;
                    m_miss++;
                    if (m_miss == int'(MISS_N)) begin m_st = 0; m_fill = 0; end
                end else begin
                    m_miss = 0;
                end
            end
        endcase
        e.qw     = m_qw;
        e.lock   = (m_st == 2);
        e.err    = mis;
        e.errcnt = 8'(m_errcnt);
    endtask

    // Holds b for one full tick period; returns on the negedge where SMPL is high
    task automatic send(input logic b);
        exp_t e;
        SIN = b;
        model_step(b, e);
        sb_q.push_back(e);
        repeat (DIV) @(negedge exCLK);
    endtask

    task automatic send_gen(input logic inv);
        send(pat[gph] ^ inv);
        gph = (gph + 1) % 8;
    endtask

    task automatic send_gated(input logic b);
        exp_t       e;
        logic [3:0] q0;
        int         c0;
        q0 = m_qw;
        c0 = m_errcnt;
        SIN = b;
        model_step(b, e);
        sb_q.push_back(e);
        repeat (2) @(negedge exCLK);
        CLKen = 1'b0;
        repeat (20) begin
            @(negedge exCLK);
            SIN = ~SIN;
            check("t5_smpl_gated", SMPL, 0);
        end
        check("t5_qw_held", QW, q0);
        check("t5_lock_held", LOCK, 1);
        check("t5_errcnt_held", ERRCNT, c0);
        SIN   = b;
        CLKen = 1'b1;
        @(negedge exCLK);
        check("t5_no_early_tick", SMPL, 0);
        @(negedge exCLK);
        check("t5_resume_tick", SMPL, 1);
        gph = (gph + 1) % 8;
    endtask

    task automatic do_reset();
        @(negedge exCLK);
        CLKen = 1'b0;
        R1    = 1'b0;
        model_reset();
        repeat (2) @(negedge exCLK);
        R1    = 1'b1;
        CLKen = 1'b1;
    endtask

    always @(negedge exCLK) begin
        if (R1 && SMPL) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_qw", QW, mon_e.qw);
                check("sb_lock", LOCK, mon_e.lock);
                check("sb_err", ERR, mon_e.err);
                check("sb_errcnt", ERRCNT, mon_e.errcnt);
            end
        end
    end

    initial begin
        do_reset();
        check("rst_qw", QW, 0);
        check("rst_lock", LOCK, 0);
        check("rst_errcnt", ERRCNT, 0);
        check("rst_smpl", SMPL, 0);

        // Clean sequence: lock after the 12th sample
        gph = 0;
        for (int k = 1; k <= 16; k++) begin
            send_gen(1'b0);
            if (k == 11) check("t1_lock_pre", LOCK, 0);
            if (k == 12) check("t1_lock", LOCK, 1);
        end

        // Single inverted sample while locked
        send_gen(1'b1);
        check("t2_errcnt", ERRCNT, 1);
        check("t2_lock", LOCK, 1);
        repeat (6) send_gen(1'b0);
        check("t2_errcnt_after", ERRCNT, 1);

        // Three inverted samples drop lock; relock after 12 good samples
        repeat (2) send_gen(1'b1);
        check("t3_lock_mid", LOCK, 1);
        send_gen(1'b1);
        check("t3_lock_drop", LOCK, 0);
        check("t3_errcnt", ERRCNT, 4);
        for (int k = 1; k <= 12; k++) begin
            send_gen(1'b0);
            if (k == 11) check("t3_relock_pre", LOCK, 0);
            if (k == 12) check("t3_relock", LOCK, 1);
        end

        // Enable gating while locked
        send_gated(pat[gph]);
        repeat (3) send_gen(1'b0);

        // Drive the error counter to FE, then past saturation
        repeat (125) begin
            send_gen(1'b1);
            send_gen(1'b1);
            send_gen(1'b0);
        end
        check("t6_errcnt_fe", ERRCNT, 8'hFE);
        send_gen(1'b1);
        send_gen(1'b0);
        send_gen(1'b1);
        check("t6_errcnt_sat", ERRCNT, 8'hFF);
        check("t6_lock", LOCK, 1);

        // Asynchronous reset between clock edges clears all outputs at once
        CLKen = 1'b0;
        #2 R1 = 1'b0;
        #1;
        check("t6_rst_qw", QW, 0);
        check("t6_rst_lock", LOCK, 0);
        check("t6_rst_err", ERR, 0);
        check("t6_rst_errcnt", ERRCNT, 0);
        check("t6_rst_smpl", SMPL, 0);
        check("t6_sb_drain", sb_q.size(), 0);

        // Alternating data never forms a legal window
        do_reset();
        for (int k = 0; k < 40; k++) send(1'(k % 2));
        check("t4_lock", LOCK, 0);
        check("t4_errcnt", ERRCNT, 0);

        CLKen = 1'b0;
        repeat (2) @(negedge exCLK);
        check("final_sb_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
